uart_tx_ctl: RTL and testbench

UART_TX_CTL -- requirements
Module: uart_tx_ctl

---
 rtl/uart_tx_ctl_if.sv | 30 +++
 rtl/uart_tx_ctl.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_ctl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctl_if
// Bundles the byte-enqueue handshake and the status/line outputs of uart_tx_ctl.
//   TX_DATA    : byte to enqueue
//   TX_VALID   : TX_DATA is valid this cycle
//   TX_READY   : FIFO can accept a byte this cycle (registered)
//   UART_TX    : serial line, idle high
//   TX_BUSY    : a frame is on the line or bytes are queued
//   FIFO_LEVEL : number of queued bytes, 0..FIFO_DEPTH
// master : the byte producer (drives TX_DATA/TX_VALID)
// slave  : the transmitter (drives everything else)
// -----------------------------------------------------------------------------
interface uart_tx_ctl_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       UART_TX;
  logic       TX_BUSY;
  logic [4:0] FIFO_LEVEL;

  modport master (
    output TX_DATA, TX_VALID,
    input  TX_READY, UART_TX, TX_BUSY, FIFO_LEVEL
  );

  modport slave (
    input  TX_DATA, TX_VALID,
    output TX_READY, UART_TX, TX_BUSY, FIFO_LEVEL
  );
endinterface

// File: rtl/uart_tx_ctl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctl
// Byte FIFO feeding an 8-bit LSB-first UART transmitter. Frames are sent
// back-to-back while the FIFO holds data.
// Parameters:
//   CLK_FREQ   : input clock frequency in Hz
//   BAUD       : line rate in bit/s; bit period DIV = round(CLK_FREQ / BAUD)
//   FIFO_DEPTH : byte FIFO depth, power of two, 2..16
// Ports:
//   SYSCLK : clock, all state on rising edge
//   RST    : asynchronous active-high reset
//   bus    : uart_tx_ctl_if.slave (TX_DATA/TX_VALID in; TX_READY, UART_TX,
//            TX_BUSY, FIFO_LEVEL out)
// Build option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit follows D7
//                       (11-bit frame); otherwise 10-bit frame.
// -----------------------------------------------------------------------------
module uart_tx_ctl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input logic          SYSCLK,
  input logic          RST,
  uart_tx_ctl_if.slave bus
);
  localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [4:0]       LEVEL_FULL = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       level_q, level_d;
  logic             ready_q, ready_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [7:0]       frame_byte_q;
  logic             push, pop, baud_end, fifo_empty;

  assign push       = bus.TX_VALID & ready_q;
  assign baud_end   = (baud_cnt_q == DIV_LAST);
  assign fifo_empty = (level_q == 5'd0);

  // FIFO storage and registered read of the byte being popped; no reset so
  // it maps onto RAM.
  always_ff @(posedge SYSCLK) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.TX_DATA;
    if (pop)  frame_byte_q      <= fifo_mem[rd_ptr_q];
  end

  // Frame sequencer
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    pop        = 1'b0;

    if (state_q != S_IDLE) baud_cnt_d = baud_end ? '0 : baud_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_d    = S_START;
          baud_cnt_d = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next START so frames have no gap.
        if (baud_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, line driver and status
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + 5'(push) - 5'(pop);
    ready_d  = (level_d != LEVEL_FULL);

    // The line follows the state register by one cycle.
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = frame_byte_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^frame_byte_q;
`endif
      default:  tx_d = 1'b1;
    endcase

    // The state_q term keeps busy up through the final stop-bit cycle on the
    // line, which lags the state register by one cycle.
    busy_d = (state_d != S_IDLE) || (level_d != 5'd0) || (state_q != S_IDLE);
  end

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      ready_q    <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.TX_READY   = ready_q;
  assign bus.UART_TX    = tx_q;
  assign bus.TX_BUSY    = busy_q;
  assign bus.FIFO_LEVEL = level_q;
endmodule

// File: tb/tb_uart_tx_ctl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctl
// Randomized and directed stimulus against a timestamp/queue model of the
// transmitter; outputs compared every cycle, plus literal frame expectations.
// Uses CLK_FREQ=1150, BAUD=100 so the bit period rounds up to 12 cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctl;
  localparam int CLK_FREQ = 1150;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 8;
  localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS         = 11;
  localparam int FRAME_CYC_LIT = 132;
  localparam logic [10:0] EXP_55 = 11'b10010101010;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
  localparam logic [10:0] EXP_3C = 11'b10001111000;
`else
  localparam int NBITS         = 10;
  localparam int FRAME_CYC_LIT = 120;
  localparam logic [10:0] EXP_55 = 11'b01010101010;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
  localparam logic [10:0] EXP_3C = 11'b01001111000;
`endif

  logic SYSCLK;
  logic RST;
  uart_tx_ctl_if bus ();

  uart_tx_ctl #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .SYSCLK(SYSCLK),
    .RST   (RST),
    .bus   (bus)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of bytes waiting; each frame occupies NBITS*DIV cycles starting at
  // the edge after its pop, and the next pop may happen exactly when it ends.
  logic [7:0] mq[$];
  int         mcyc;
  int         last_pop;
  bit         have_pop;
  logic [7:0] cur;
  bit         mready;

  always @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      have_pop = 1'b0;
      mready   = 1'b1;
      mcyc     = 0;
      last_pop = 0;
    end else begin
      bit acc;
      bit pop_now;
      mcyc++;
      acc     = bus.TX_VALID && mready;
      pop_now = (!have_pop || (mcyc - last_pop >= NBITS * DIV)) && (mq.size() != 0);
      if (pop_now) begin
        cur      = mq.pop_front();
        last_pop = mcyc;
        have_pop = 1'b1;
      end
      if (acc) mq.push_back(bus.TX_DATA);
      mready = (mq.size() != DEPTH);
    end
  end

  always @(negedge SYSCLK) begin
    if (!RST) begin
      int   off;
      int   k;
      logic e_tx;
      logic e_busy;
      off  = mcyc - last_pop;
      e_tx = 1'b1;
      if (have_pop && off >= 1 && off <= NBITS * DIV) begin
        k = (off - 1) / DIV;
        if (k == 0)                     e_tx = 1'b0;
        else if (k <= 8)                e_tx = cur[k-1];
        else if (k == 9 && NBITS == 11) e_tx = ^cur;
      end
      e_busy = (mq.size() != 0) || (have_pop && off <= NBITS * DIV);
      chk("cyc_uart_tx", 32'(bus.UART_TX), 32'(e_tx));
      chk("cyc_busy",    32'(bus.TX_BUSY), 32'(e_busy));
      chk("cyc_ready",   32'(bus.TX_READY), 32'(mready));
      chk("cyc_level",   32'(bus.FIFO_LEVEL), 32'(mq.size()));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int n = 0;
    while (bus.TX_BUSY && n < 20 * NBITS * DIV) begin
      @(posedge SYSCLK); #1;
      n++;
    end
    chk("idle_wait", 32'(bus.TX_BUSY), 32'd0);
  endtask

  // Precondition: TX_VALID/TX_DATA already driven, FIFO empty, line idle;
  // the next rising edge is the accept edge E.
  task automatic frame_check(input string tag, input logic [10:0] exp_bits);
    int n;
    @(posedge SYSCLK); #1;
    bus.TX_VALID = 1'b0;
    chk({tag, "_level_e"}, 32'(bus.FIFO_LEVEL), 32'd1);
    chk({tag, "_busy_e"}, 32'(bus.TX_BUSY), 32'd1);
    @(posedge SYSCLK); #1;
    chk({tag, "_level_e1"}, 32'(bus.FIFO_LEVEL), 32'd0);
    chk({tag, "_tx_e1"}, 32'(bus.UART_TX), 32'd1);
    @(posedge SYSCLK); #1;
    chk({tag, "_tx_e2"}, 32'(bus.UART_TX), 32'd0);
    n = 0;
    while (bus.TX_BUSY && n < 2 * NBITS * DIV) begin
      @(posedge SYSCLK); #1;
      n++;
      if ((n % DIV) == DIV / 2 && (n / DIV) < NBITS)
        chk($sformatf("%s_bit%0d", tag, n / DIV), 32'(bus.UART_TX), 32'(exp_bits[n / DIV]));
    end
    chk({tag, "_frame_len"}, 32'(n), 32'(FRAME_CYC_LIT));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int pct [3] = '{1, 10, 90};

  initial begin
    RST = 1'b1;
    bus.TX_VALID = 1'b0;
    bus.TX_DATA  = 8'h00;
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    chk("rst_tx",    32'(bus.UART_TX), 32'd1);
    chk("rst_ready", 32'(bus.TX_READY), 32'd1);
    chk("rst_busy",  32'(bus.TX_BUSY), 32'd0);
    chk("rst_level", 32'(bus.FIFO_LEVEL), 32'd0);

    // Byte presented before release: must be taken on the first edge.
    bus.TX_VALID = 1'b1;
    bus.TX_DATA  = 8'h55;
    #2 RST = 1'b0;
    frame_check("b55", EXP_55);

    wait_idle();
    @(posedge SYSCLK); #1;
    bus.TX_VALID = 1'b1;
    bus.TX_DATA  = 8'h07;
    frame_check("b07", EXP_07);

    // Ten consecutive writes: first pops at once, FIFO fills, tenth refused.
    wait_idle();
    @(posedge SYSCLK); #1;
    bus.TX_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.TX_DATA = 8'(8'h10 + i);
      @(posedge SYSCLK); #1;
    end
    chk("fill_level", 32'(bus.FIFO_LEVEL), 32'd8);
    chk("fill_ready", 32'(bus.TX_READY), 32'd0);
    for (int i = 0; i < 40; i++) begin
      bus.TX_DATA = 8'($urandom);
      @(posedge SYSCLK); #1;
    end
    bus.TX_VALID = 1'b0;
    wait_idle();

    // Reset during D3 of 0xA3 with three bytes queued.
    @(posedge SYSCLK); #1;
    bus.TX_VALID = 1'b1;
    bus.TX_DATA  = 8'hA3;
    @(posedge SYSCLK); #1; bus.TX_DATA = 8'h11;
    @(posedge SYSCLK); #1; bus.TX_DATA = 8'h22;
    @(posedge SYSCLK); #1; bus.TX_DATA = 8'h33;
    @(posedge SYSCLK); #1; bus.TX_VALID = 1'b0;
    repeat (4 * DIV + DIV / 2 - 1) @(posedge SYSCLK);
    @(negedge SYSCLK);
    chk("pre_rst_d3",    32'(bus.UART_TX), 32'd0);
    chk("pre_rst_level", 32'(bus.FIFO_LEVEL), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_tx",    32'(bus.UART_TX), 32'd1);
    chk("mid_rst_level", 32'(bus.FIFO_LEVEL), 32'd0);
    chk("mid_rst_ready", 32'(bus.TX_READY), 32'd1);
    chk("mid_rst_busy",  32'(bus.TX_BUSY), 32'd0);
    repeat (2) @(negedge SYSCLK);
    #2 RST = 1'b0;
    bus.TX_VALID = 1'b1;
    bus.TX_DATA  = 8'h3C;
    frame_check("b3C", EXP_3C);

    // Random traffic at light, medium and saturating load.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        bus.TX_VALID = ($urandom_range(0, 99) < pct[ph]);
        bus.TX_DATA  = 8'($urandom);
        @(posedge SYSCLK); #1;
      end
    end
    bus.TX_VALID = 1'b0;
    wait_idle();
    repeat (3) @(posedge SYSCLK);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
